// File: rtl/softmax_row_dispatcher.sv
// Round-robin dispatcher of B2R row tiles onto the bank of per-row softmax units.
// Each row is owned by one unit; tiles are re-registered and strobed to that unit.
module softmax_row_dispatcher #(
  parameter int unsigned WIDTH              = 16,
  parameter int unsigned COL                = 64,
  parameter int unsigned TILE_SIZE          = 8,
  parameter int unsigned NUM_CORES_A_Qn_KnT = 2,
  parameter int unsigned BLOCK_SIZE         = 2,
  parameter int unsigned NUM_ROWS           = 8,
  localparam int unsigned NUM_TILES = COL / TILE_SIZE,
  localparam int unsigned NUM_SM    = NUM_CORES_A_Qn_KnT * BLOCK_SIZE,
  localparam int unsigned TILE_W    = WIDTH * TILE_SIZE,
  localparam int unsigned IDX_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TILE_W-1:0] in_tile,
  input  logic [NUM_SM-1:0] sm_free_done,
  output logic [NUM_SM-1:0] sm_valid,
  output logic [TILE_W-1:0] sm_tile,
  output logic [IDX_W-1:0]  sm_tile_idx,
  output logic              sm_row_first,
  output logic              sm_row_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PTR_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_UNIT, STREAM, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic [IDX_W-1:0]  tile_cnt_q, tile_cnt_d;
  logic [NUM_SM-1:0] free_q, free_d;
  logic [NUM_SM-1:0] sm_valid_q, sm_valid_d;
  logic [TILE_W-1:0] sm_tile_q, sm_tile_d;
  logic [IDX_W-1:0]  sm_tile_idx_q, sm_tile_idx_d;
  logic              row_first_q, row_first_d;
  logic              row_last_q, row_last_d;
  logic [NUM_SM-1:0] ptr_oh_c;
  logic              ptr_free_c;
  logic              tile_last_c;

  // Decode the round-robin pointer into a unit select.
  always_comb begin
    ptr_oh_c = '0;
    for (int unsigned k = 0; k < NUM_SM; k++) begin
      if (ptr_q == PTR_W'(k)) ptr_oh_c[k] = 1'b1;
    end
    ptr_free_c  = |(free_q & ptr_oh_c);
    tile_last_c = (tile_cnt_q == IDX_W'(NUM_TILES - 1));
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    row_cnt_d     = row_cnt_q;
    tile_cnt_d    = tile_cnt_q;
    free_d        = free_q | sm_free_done;
    sm_valid_d    = '0;
    sm_tile_d     = sm_tile_q;
    sm_tile_idx_d = sm_tile_idx_q;
    row_first_d   = 1'b0;
    row_last_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT_UNIT;
          ptr_d     = '0;
          row_cnt_d = '0;
        end
      end
      WAIT_UNIT: begin
        if (ptr_free_c) begin
          state_d    = STREAM;
          tile_cnt_d = '0;
        end
      end
      STREAM: begin
        if (in_valid) begin
          sm_valid_d    = ptr_oh_c;
          sm_tile_d     = in_tile;
          sm_tile_idx_d = tile_cnt_q;
          row_first_d   = (tile_cnt_q == '0);
          row_last_d    = tile_last_c;
          // Claiming the unit overrides a coincident free pulse.
          if (tile_cnt_q == '0) free_d = free_d & ~ptr_oh_c;
          if (tile_last_c) begin
            tile_cnt_d = '0;
            ptr_d      = (ptr_q == PTR_W'(NUM_SM - 1)) ? '0 : ptr_q + PTR_W'(1);
            if (row_cnt_q == ROW_W'(NUM_ROWS - 1)) begin
              state_d = DRAIN;
            end else begin
              row_cnt_d = row_cnt_q + ROW_W'(1);
              state_d   = WAIT_UNIT;
            end
          end else begin
            tile_cnt_d = tile_cnt_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (&free_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      row_cnt_q     <= '0;
      tile_cnt_q    <= '0;
      free_q        <= '1;
      sm_valid_q    <= '0;
      sm_tile_q     <= '0;
      sm_tile_idx_q <= '0;
      row_first_q   <= 1'b0;
      row_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      row_cnt_q     <= row_cnt_d;
      tile_cnt_q    <= tile_cnt_d;
      free_q        <= free_d;
      sm_valid_q    <= sm_valid_d;
      sm_tile_q     <= sm_tile_d;
      sm_tile_idx_q <= sm_tile_idx_d;
      row_first_q   <= row_first_d;
      row_last_q    <= row_last_d;
    end
  end

  // Handshake and status are pure decodes of the state register.
  assign in_ready     = (state_q == STREAM);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign sm_valid     = sm_valid_q;
  assign sm_tile      = sm_tile_q;
  assign sm_tile_idx  = sm_tile_idx_q;
  assign sm_row_first = row_first_q;
  assign sm_row_last  = row_last_q;

endmodule

// File: tb/tb_softmax_row_dispatcher.sv
// Bench for softmax_row_dispatcher: default 4-unit/8-tile configuration plus a
// 1-unit/1-tile/1-row instance, checked against a beat-level reference model.
module tb_softmax_row_dispatcher;

  localparam int NT       = 8;
  localparam int NSM      = 4;
  localparam int NROWS    = 8;
  localparam int TW       = 128;
  localparam int FREE_DLY = 20;
  localparam int LIMIT    = 2000;

  typedef struct packed {
    int          cyc;
    int          unit;
    int          idx;
    bit          row_first;
    bit          row_last;
    logic [TW-1:0] data;
  } beat_t;

  typedef struct packed {
    int          cyc;
    logic [TW-1:0] data;
  } acc_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           in_valid;
  logic           in_ready;
  logic [TW-1:0]  in_tile;
  logic [NSM-1:0] sm_free_done;
  logic [NSM-1:0] sm_valid;
  logic [TW-1:0]  sm_tile;
  logic [2:0]     sm_tile_idx;
  logic           sm_row_first;
  logic           sm_row_last;
  logic           busy;
  logic           done;

  logic           b_start;
  logic           b_in_valid;
  logic           b_in_ready;
  logic [TW-1:0]  b_in_tile;
  logic [0:0]     b_free;
  logic [0:0]     b_sm_valid;
  logic [TW-1:0]  b_sm_tile;
  logic [0:0]     b_sm_tile_idx;
  logic           b_first;
  logic           b_last;
  logic           b_busy;
  logic           b_done;

  logic [NSM-1:0] auto_free;
  logic [NSM-1:0] extra_free;
  int             mode;
  int             hold0;
  int             cyc = 0;
  int             rel_at [NSM] = '{default: -1};
  int             done_cnt = 0;
  int             bad_onehot = 0;
  int             mon_u;
  int             checks = 0;
  int             errors = 0;
  acc_t           acc_q[$];
  beat_t          obs_q[$];
  beat_t          exp_q[$];

  assign sm_free_done = auto_free | extra_free;

  softmax_row_dispatcher #(
    .WIDTH(16), .COL(64), .TILE_SIZE(8), .NUM_CORES_A_Qn_KnT(2), .BLOCK_SIZE(2), .NUM_ROWS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_tile(in_tile), .sm_free_done(sm_free_done), .sm_valid(sm_valid), .sm_tile(sm_tile),
    .sm_tile_idx(sm_tile_idx), .sm_row_first(sm_row_first), .sm_row_last(sm_row_last),
    .busy(busy), .done(done)
  );

  softmax_row_dispatcher #(
    .WIDTH(16), .COL(8), .TILE_SIZE(8), .NUM_CORES_A_Qn_KnT(1), .BLOCK_SIZE(1), .NUM_ROWS(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_tile(b_in_tile), .sm_free_done(b_free), .sm_valid(b_sm_valid), .sm_tile(b_sm_tile),
    .sm_tile_idx(b_sm_tile_idx), .sm_row_first(b_first), .sm_row_last(b_last),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // B2R source: mode 0 always valid, mode 1 alternating, otherwise idle.
  initial in_valid = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mode == 0) in_valid = 1'b1;
    else if (mode == 1) in_valid = ~in_valid;
    else in_valid = 1'b0;
    in_tile = {$urandom, $urandom, $urandom, $urandom};
  end

  // Softmax unit model: frees a unit FREE_DLY cycles after its last tile.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NSM; k++) auto_free[k] = (rel_at[k] == cyc);
  end

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_q.push_back('{cyc: cyc, data: in_tile});
    if (sm_valid != '0) begin
      mon_u = 0;
      for (int k = 0; k < NSM; k++) if (sm_valid[k]) mon_u = k;
      if (!$onehot(sm_valid)) bad_onehot++;
      obs_q.push_back('{cyc: cyc, unit: mon_u, idx: int'(sm_tile_idx),
                        row_first: sm_row_first, row_last: sm_row_last, data: sm_tile});
      if (sm_row_last)
        rel_at[mon_u] = (mon_u == 0 && hold0 > cyc + FREE_DLY) ? hold0 : cyc + FREE_DLY;
    end
    if (done) done_cnt++;
  end

  // Reference: k-th accepted beat is tile k%NT of row k/NT, owned by unit (k/NT)%NSM,
  // and appears on the unit side exactly one cycle after acceptance.
  function automatic void build_exp(input int ab);
    beat_t e;
    exp_q.delete();
    for (int i = 0; i < NROWS * NT && ab + i < acc_q.size(); i++) begin
      e.cyc       = acc_q[ab + i].cyc + 1;
      e.unit      = (i / NT) % NSM;
      e.idx       = i % NT;
      e.row_first = (e.idx == 0);
      e.row_last  = (e.idx == NT - 1);
      e.data      = acc_q[ab + i].data;
      exp_q.push_back(e);
    end
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    int t = 0;
    seen = 1'b0;
    while (t < LIMIT && !seen) begin
      @(negedge clk);
      t++;
      seen = done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 2; hold0 = 0; extra_free = '0;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_tile = '0; b_free = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, sm_valid, sm_tile, sm_tile_idx, sm_row_first, sm_row_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a: got rdy=%b v=%b idx=%0d f=%b l=%b busy=%b done=%b tile=%h, want all 0",
               in_ready, sm_valid, sm_tile_idx, sm_row_first, sm_row_last, busy, done, sm_tile);
    end
    checks++;
    if ({b_in_ready, b_sm_valid, b_sm_tile, b_sm_tile_idx, b_first, b_last, b_busy, b_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: got rdy=%b v=%b busy=%b done=%b, want all 0",
               b_in_ready, b_sm_valid, b_busy, b_done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b in_ready=%b, want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic_pass();
    int ab, ob, dc, n;
    bit seen;
    mode = 0;
    ab = acc_q.size(); ob = obs_q.size(); dc = done_cnt;
    pulse_start();
    wait_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_done_timeout: got no done, want done within %0d", LIMIT); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_at_done: got %b want 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (done_cnt - dc != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - dc); end
    build_exp(ab);
    n = obs_q.size() - ob;
    checks++;
    if (n != NROWS * NT) begin errors++; $display("FAIL basic_beat_count: got %0d want %0d", n, NROWS * NT); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[ob + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_beat[%0d]: got unit=%0d idx=%0d f=%b l=%b cyc=%0d data=%h, want unit=%0d idx=%0d f=%b l=%b cyc=%0d data=%h",
                 i, obs_q[ob+i].unit, obs_q[ob+i].idx, obs_q[ob+i].row_first, obs_q[ob+i].row_last, obs_q[ob+i].cyc, obs_q[ob+i].data,
                 exp_q[i].unit, exp_q[i].idx, exp_q[i].row_first, exp_q[i].row_last, exp_q[i].cyc, exp_q[i].data);
      end
    end
  endtask

  task automatic test_unit_stall();
    int ab, ob, sc, n, rdy_bad, stall_beats;
    bit seen;
    mode = 0;
    ab = acc_q.size(); ob = obs_q.size();
    pulse_start();
    sc = cyc;
    hold0 = sc + 200;
    rdy_bad = 0;
    do begin
      @(negedge clk);
      if (cyc >= sc + 50 && cyc <= hold0 + 1 && in_ready) rdy_bad++;
    end while (cyc < hold0 + 2);
    checks++;
    if (rdy_bad != 0) begin errors++; $display("FAIL stall_ready_low: got %0d ready cycles in stall, want 0", rdy_bad); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_resume: got %b two cycles after free pulse, want 1", in_ready); end
    wait_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_done_timeout: got no done, want done within %0d", LIMIT); end
    @(negedge clk);
    hold0 = 0;
    stall_beats = 0;
    for (int i = ob; i < obs_q.size(); i++)
      if (obs_q[i].cyc >= sc + 50 && obs_q[i].cyc <= hold0 + sc + 202) stall_beats++;
    checks++;
    if (stall_beats != 0) begin errors++; $display("FAIL stall_no_valid: got %0d beats during stall, want 0", stall_beats); end
    build_exp(ab);
    n = obs_q.size() - ob;
    checks++;
    if (n != NROWS * NT) begin errors++; $display("FAIL stall_beat_count: got %0d want %0d", n, NROWS * NT); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[ob + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_beat[%0d]: got unit=%0d idx=%0d cyc=%0d data=%h, want unit=%0d idx=%0d cyc=%0d data=%h",
                 i, obs_q[ob+i].unit, obs_q[ob+i].idx, obs_q[ob+i].cyc, obs_q[ob+i].data,
                 exp_q[i].unit, exp_q[i].idx, exp_q[i].cyc, exp_q[i].data);
      end
    end
  endtask

  task automatic test_valid_gaps();
    int ab, ob, n;
    bit seen;
    mode = 1;
    ab = acc_q.size(); ob = obs_q.size();
    pulse_start();
    wait_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL gaps_done_timeout: got no done, want done within %0d", LIMIT); end
    @(negedge clk);
    mode = 0;
    build_exp(ab);
    n = obs_q.size() - ob;
    checks++;
    if (n != NROWS * NT) begin errors++; $display("FAIL gaps_beat_count: got %0d want %0d", n, NROWS * NT); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[ob + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gaps_beat[%0d]: got unit=%0d idx=%0d cyc=%0d data=%h, want unit=%0d idx=%0d cyc=%0d data=%h",
                 i, obs_q[ob+i].unit, obs_q[ob+i].idx, obs_q[ob+i].cyc, obs_q[ob+i].data,
                 exp_q[i].unit, exp_q[i].idx, exp_q[i].cyc, exp_q[i].data);
      end
    end
  endtask

  task automatic test_mid_row_reset();
    int ab, ob, n, t;
    bit seen;
    mode = 0;
    ab = acc_q.size();
    pulse_start();
    t = 0;
    do begin @(negedge clk); #1; t++; end while (acc_q.size() - ab < 2 * NT + 4 && t < LIMIT);
    checks++;
    if (acc_q.size() - ab < 2 * NT + 4) begin
      errors++; $display("FAIL midreset_reach_row2: got %0d beats, want %0d", acc_q.size() - ab, 2 * NT + 4);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, sm_valid, sm_tile, sm_tile_idx, sm_row_first, sm_row_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b v=%b idx=%0d f=%b l=%b busy=%b done=%b, want all 0",
               in_ready, sm_valid, sm_tile_idx, sm_row_first, sm_row_last, busy, done);
    end
    repeat (40) @(negedge clk);
    ab = acc_q.size(); ob = obs_q.size();
    pulse_start();
    wait_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL midreset_done_timeout: got no done, want done within %0d", LIMIT); end
    @(negedge clk);
    build_exp(ab);
    n = obs_q.size() - ob;
    checks++;
    if (n != NROWS * NT) begin errors++; $display("FAIL midreset_beat_count: got %0d want %0d", n, NROWS * NT); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[ob + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_beat[%0d]: got unit=%0d idx=%0d cyc=%0d, want unit=%0d idx=%0d cyc=%0d",
                 i, obs_q[ob+i].unit, obs_q[ob+i].idx, obs_q[ob+i].cyc, exp_q[i].unit, exp_q[i].idx, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_start_ignored();
    int ab, ob, n, dc, t;
    bit seen;
    mode = 0;
    ab = acc_q.size(); ob = obs_q.size(); dc = done_cnt;
    pulse_start();
    t = 0;
    do begin @(negedge clk); #1; t++; end while (acc_q.size() - ab < 3 && t < LIMIT);
    @(posedge clk); #1 start = 1'b1; extra_free = 4'b1000;
    @(posedge clk); #1 start = 1'b0; extra_free = '0;
    wait_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL ignore_done_timeout: got no done, want done within %0d", LIMIT); end
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt - dc != 1) begin
      errors++; $display("FAIL ignore_no_second_pass: got busy=%b done_count=%0d, want 0 1", busy, done_cnt - dc);
    end
    build_exp(ab);
    n = obs_q.size() - ob;
    checks++;
    if (n != NROWS * NT) begin errors++; $display("FAIL ignore_beat_count: got %0d want %0d", n, NROWS * NT); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[ob + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ignore_beat[%0d]: got unit=%0d idx=%0d cyc=%0d, want unit=%0d idx=%0d cyc=%0d",
                 i, obs_q[ob+i].unit, obs_q[ob+i].idx, obs_q[ob+i].cyc, exp_q[i].unit, exp_q[i].idx, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_single_tile();
    logic [TW-1:0] d;
    int done_hi;
    d = {$urandom, $urandom, $urandom, $urandom};
    b_in_tile = d; b_in_valid = 1'b1;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    @(negedge clk);
    checks++;
    if (b_in_ready !== 1'b0 || b_busy !== 1'b1) begin
      errors++; $display("FAIL single_wait_unit: got ready=%b busy=%b, want 0 1", b_in_ready, b_busy);
    end
    @(negedge clk);
    checks++;
    if (b_in_ready !== 1'b1) begin errors++; $display("FAIL single_stream_ready: got %b want 1", b_in_ready); end
    @(posedge clk); #1 b_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b_sm_valid !== 1'b1 || b_first !== 1'b1 || b_last !== 1'b1 || b_sm_tile_idx !== 1'b0 || b_sm_tile !== d) begin
      errors++;
      $display("FAIL single_beat: got v=%b f=%b l=%b idx=%0d data=%h, want v=1 f=1 l=1 idx=0 data=%h",
               b_sm_valid, b_first, b_last, b_sm_tile_idx, b_sm_tile, d);
    end
    done_hi = 0;
    repeat (4) begin @(negedge clk); if (b_done || !b_busy) done_hi++; end
    checks++;
    if (done_hi != 0) begin errors++; $display("FAIL single_drain_hold: got %0d early done/idle cycles, want 0", done_hi); end
    @(posedge clk); #1 b_free = 1'b1;
    @(posedge clk); #1 b_free = 1'b0;
    @(negedge clk);
    checks++;
    if (b_done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b want 0", b_done); end
    @(negedge clk);
    checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b1) begin
      errors++; $display("FAIL single_done_pulse: got done=%b busy=%b, want 1 1", b_done, b_busy);
    end
    @(negedge clk);
    checks++;
    if (b_done !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL single_after_done: got done=%b busy=%b, want 0 0", b_done, b_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_unit_stall();
    test_valid_gaps();
    test_mid_row_reset();
    test_start_ignored();
    test_single_tile();
    checks++;
    if (bad_onehot != 0) begin errors++; $display("FAIL sm_valid_onehot: got %0d non-one-hot strobes, want 0", bad_onehot); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
